config_chain_loader: RTL

// - Sequences the tile configuration chain: serialises bitstream words onto CONFin and drives
//   the two non-overlapping shift phases (CLK-enabled / MODE-enabled latches) plus the config-mode flag.
// - Sits between the fabric config port (word stream in) and the head of a tile's latch chain;

---
 rtl/config_chain_loader_if.sv | 11 +
 rtl/config_chain_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/config_chain_loader_if.sv
// Word-stream port feeding the configuration chain loader.
interface config_chain_loader_if #(
  parameter int WORD_W = 4
);
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/config_chain_loader.sv
// Serialises config words onto a master/slave latch chain with non-overlapping phase pulses.
// Optional readback of the chain tail is enabled by defining CONF_READBACK_EN.
//
// state | meaning
// IDLE  | waiting for the first word of a frame
// LOAD  | mid-frame, waiting for the next word (phases low, stall allowed)
// PHA   | phase A pulse high, conf_data valid
// GAPA  | non-overlap guard after phase A
// PHB   | phase B pulse high
// GAPB  | non-overlap guard after phase B, bit committed at its end
// DONE  | one-cycle frame-complete pulse
module config_chain_loader #(
  parameter int CHAIN_LEN = 8,
  parameter int WORD_W    = 4,
  parameter int PULSE_W   = 1,
  parameter int GAP_W     = 1
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  config_chain_loader_if.slave   s_if,
  output logic                   conf_data,
  output logic                   conf_pha,
  output logic                   conf_phb,
  output logic                   conf_mode,
  input  logic                   conf_tail,
  output logic                   busy,
  output logic                   done
`ifdef CONF_READBACK_EN
  ,
  output logic [WORD_W-1:0]      rb_data,
  output logic                   rb_valid
`endif
);

  localparam int TMAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int CW   = $clog2(CHAIN_LEN + WORD_W + 1);

  localparam logic [TW-1:0] PULSE_C = TW'(PULSE_W - 1);
  localparam logic [TW-1:0] GAP_C   = TW'(GAP_W - 1);
  localparam logic [CW-1:0] CHAIN_C = CW'(CHAIN_LEN);
  localparam logic [CW-1:0] WORD_C  = CW'(WORD_W);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PHA  = 3'd2,
    GAPA = 3'd3,
    PHB  = 3'd4,
    GAPB = 3'd5,
    DONE = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]     wbits_q, wbits_d;

  logic              hs;
  logic              in_bit;
  logic [CW-1:0]     remaining;
  logic [CW-1:0]     bit_inc;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      wbits_q   <= '0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      wbits_q   <= wbits_d;
    end
  end

  assign s_if.s_ready = (state_q == IDLE) || (state_q == LOAD);
  assign hs           = s_if.s_valid && s_if.s_ready;
  // A word taken in IDLE always starts a fresh frame, whatever the counter holds.
  assign remaining    = CHAIN_C - ((state_q == LOAD) ? bit_cnt_q : '0);
  assign bit_inc      = bit_cnt_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    wbits_d   = wbits_q;
    case (state_q)
      IDLE, LOAD: begin
        if (hs) begin
          sh_d      = s_if.s_data;
          wbits_d   = (remaining < WORD_C) ? remaining : WORD_C;
          tmr_d     = PULSE_C;
          state_d   = PHA;
          if (state_q == IDLE) bit_cnt_d = '0;
        end
      end
      PHA: begin
        if (tmr_q == '0) begin
          tmr_d   = GAP_C;
          state_d = GAPA;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      GAPA: begin
        if (tmr_q == '0) begin
          tmr_d   = PULSE_C;
          state_d = PHB;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      PHB: begin
        if (tmr_q == '0) begin
          tmr_d   = GAP_C;
          state_d = GAPB;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      GAPB: begin
        if (tmr_q == '0) begin
          sh_d      = sh_q << 1;
          bit_cnt_d = bit_inc;
          wbits_d   = wbits_q - CW'(1);
          tmr_d     = PULSE_C;
          if (bit_inc == CHAIN_C)        state_d = DONE;
          else if (wbits_q == CW'(1))    state_d = LOAD;
          else                           state_d = PHA;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      DONE: begin
        bit_cnt_d = '0;
        wbits_d   = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_bit    = (state_q == PHA) || (state_q == GAPA) ||
                     (state_q == PHB) || (state_q == GAPB);
  assign conf_data = in_bit & sh_q[WORD_W-1];
  assign conf_pha  = (state_q == PHA);
  assign conf_phb  = (state_q == PHB);
  assign conf_mode = in_bit || (state_q == LOAD);
  assign busy      = conf_mode;
  assign done      = (state_q == DONE);

`ifdef CONF_READBACK_EN
  localparam int RBW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [RBW-1:0] RB_FULL = RBW'(WORD_W - 1);

  logic [WORD_W-1:0] rb_sh_q, rb_sh_d;
  logic [RBW-1:0]    rb_cnt_q, rb_cnt_d;
  logic [WORD_W-1:0] rb_data_q, rb_data_d;
  logic              rb_valid_q, rb_valid_d;
  logic              rb_sample;
  logic [WORD_W-1:0] rb_shifted;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rb_sh_q    <= '0;
      rb_cnt_q   <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_sh_q    <= rb_sh_d;
      rb_cnt_q   <= rb_cnt_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  // Tail is sampled once per bit, on the first cycle of the phase A pulse.
  assign rb_sample  = (state_q == PHA) && (tmr_q == PULSE_C);
  assign rb_shifted = (rb_sh_q << 1) | WORD_W'(conf_tail);

  always_comb begin
    rb_sh_d    = rb_sh_q;
    rb_cnt_d   = rb_cnt_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;
    if (rb_sample) begin
      if (rb_cnt_q == RB_FULL) begin
        rb_data_d  = rb_shifted;
        rb_valid_d = 1'b1;
        rb_sh_d    = '0;
        rb_cnt_d   = '0;
      end else begin
        rb_sh_d  = rb_shifted;
        rb_cnt_d = rb_cnt_q + RBW'(1);
      end
    end else if ((state_q == DONE) && (rb_cnt_q != '0)) begin
      rb_data_d  = rb_sh_q;
      rb_valid_d = 1'b1;
      rb_sh_d    = '0;
      rb_cnt_d   = '0;
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;
`else
  logic unused_conf_tail;
  assign unused_conf_tail = conf_tail;
`endif

endmodule
